// File: rtl/axis_pkg.sv
// Shared types and constants for the multi-channel AXI write path.
package axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic REG_BASE  = 1'b0;
  localparam logic REG_COUNT = 1'b1;

  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_BITS  = 12;

  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int beat_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping; combinational.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   k;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found     = 1'b1;
        gnt_oh[k] = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/axis_write_mc.sv
// Multiplexes CHANNELS programmed stream inputs onto one AXI write port, one burst per grant.
// Grant->awvalid 1 cycle; upstream stalls drop wvalid while the grant is held until wlast.
module axis_write_mc
  import axis_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CFG_AWIDTH     = 5,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MAX_BURST      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CFG_AWIDTH-1:0]              cfg_addr,
  input  logic [CFG_DWIDTH-1:0]              cfg_data,
  input  logic                               cfg_valid,
  input  logic [CHANNELS-1:0]                s_valid,
  input  logic [CHANNELS*AXI_DATA_WIDTH-1:0] s_data,
  output logic [CHANNELS-1:0]                s_ready,
  output logic [CHANNELS-1:0]                busy,
  output logic [CHANNELS-1:0]                done,
  output logic [AXI_ID_WIDTH-1:0]            axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]          axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]           axi_awlen,
  output logic                               axi_awvalid,
  input  logic                               axi_awready,
  output logic [AXI_ID_WIDTH-1:0]            axi_wid,
  output logic [AXI_DATA_WIDTH-1:0]          axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]        axi_wstrb,
  output logic                               axi_wlast,
  output logic                               axi_wvalid,
  input  logic                               axi_wready,
  output logic                               axi_bready
);

  localparam int IDXW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SELW  = CFG_AWIDTH - 1;
  localparam int BYTES = beat_bytes(AXI_DATA_WIDTH);
  localparam int SHIFT = beat_shift(AXI_DATA_WIDTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK = AXI_ADDR_WIDTH'(BYTES - 1);
  localparam logic [PAGE_BITS:0]        PAGE_SZ  = PAGE_BYTES[PAGE_BITS:0];

  state_t                    state, state_nx;
  logic [AXI_ADDR_WIDTH-1:0] ch_addr [CHANNELS];
  logic [CFG_DWIDTH-1:0]     ch_rem  [CHANNELS];
  logic [CHANNELS-1:0]       ch_busy;
  logic [IDXW-1:0]           rr_ptr, gnt_idx, arb_idx;
  logic [CHANNELS-1:0]       arb_oh;
  logic                      arb_vld;
  logic [AXI_LEN_WIDTH-1:0]  beat_cnt;
  logic                      beat_acc;
  logic [SELW-1:0]           cfg_sel;
  logic [AXI_DATA_WIDTH-1:0] s_dat [CHANNELS];

  logic [AXI_ADDR_WIDTH-1:0] cand_addr;
  logic [CFG_DWIDTH-1:0]     cand_rem;
  logic [PAGE_BITS:0]        page_left;
  logic [31:0]               burst_beats;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
    assign s_dat[c] = s_data[c*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

  assign cfg_sel    = cfg_addr[CFG_AWIDTH-1:1];
  assign busy       = ch_busy;
  assign axi_awid   = AXI_ID_WIDTH'(gnt_idx);
  assign axi_wid    = AXI_ID_WIDTH'(gnt_idx);
  assign axi_wstrb  = '1;
  assign axi_bready = 1'b1;

  axis_rr_arbiter #(
    .N  (CHANNELS),
    .IW (IDXW)
  ) u_arb (
    .req     (ch_busy & s_valid),
    .ptr     (rr_ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  assign arb_vld = |arb_oh;

  // Burst never runs past the channel's remaining beats, MAX_BURST, or the next 4 KiB page.
  always_comb begin
    cand_addr   = ch_addr[arb_idx];
    cand_rem    = ch_rem[arb_idx];
    page_left   = PAGE_SZ - {1'b0, cand_addr[PAGE_BITS-1:0]};
    burst_beats = 32'(MAX_BURST);
    if (32'(page_left >> SHIFT) < burst_beats) burst_beats = 32'(page_left >> SHIFT);
    if (32'(cand_rem) < burst_beats) burst_beats = 32'(cand_rem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_wdata   = '0;
    axi_wlast   = 1'b0;
    s_ready     = '0;
    beat_acc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_vld) state_nx = ST_ADDR;
      end
      ST_ADDR: begin
        axi_awvalid = 1'b1;
        if (axi_awready) state_nx = ST_DATA;
      end
      ST_DATA: begin
        axi_wvalid       = s_valid[gnt_idx];
        axi_wdata        = s_dat[gnt_idx];
        axi_wlast        = (beat_cnt == axi_awlen);
        s_ready[gnt_idx] = axi_wready;
        beat_acc         = s_valid[gnt_idx] & axi_wready;
        if (beat_acc && axi_wlast) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ch_addr[c] <= '0;
        ch_rem[c]  <= '0;
      end
      ch_busy    <= '0;
      done       <= '0;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      axi_awaddr <= '0;
      axi_awlen  <= '0;
      beat_cnt   <= '0;
    end else begin
      done <= '0;
      if (state == ST_IDLE && arb_vld) begin
        gnt_idx    <= arb_idx;
        axi_awaddr <= cand_addr;
        axi_awlen  <= AXI_LEN_WIDTH'(burst_beats - 32'd1);
      end
      if (state == ST_ADDR && axi_awready) beat_cnt <= '0;
      if (beat_acc) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (axi_wlast) begin
          if (gnt_idx == IDXW'(CHANNELS - 1)) rr_ptr <= '0;
          else                                rr_ptr <= gnt_idx + 1'b1;
        end
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (beat_acc && int'(gnt_idx) == c) begin
          ch_rem[c]  <= ch_rem[c] - 1'b1;
          ch_addr[c] <= ch_addr[c] + AXI_ADDR_WIDTH'(BYTES);
          if (ch_rem[c] == CFG_DWIDTH'(1)) begin
            ch_busy[c] <= 1'b0;
            done[c]    <= 1'b1;
          end
        end
        // A busy channel (including one finishing this cycle) ignores cfg writes.
        if (cfg_valid && int'(cfg_sel) == c && !ch_busy[c]) begin
          if (cfg_addr[0] == REG_BASE) begin
            ch_addr[c] <= AXI_ADDR_WIDTH'(cfg_data) & ~LOW_MASK;
          end else if (cfg_addr[0] == REG_COUNT && cfg_data != '0) begin
            ch_rem[c]  <= cfg_data;
            ch_busy[c] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_write_mc.sv
// Randomized and directed bench for axis_write_mc against a transaction-level model.
module tb_axis_write_mc;

  localparam int CH   = 4;
  localparam int DW   = 64;
  localparam int AW   = 32;
  localparam int IW   = 8;
  localparam int LW   = 8;
  localparam int CAW  = 5;
  localparam int CDW  = 32;
  localparam int MAXB = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CAW-1:0]   cfg_addr;
  logic [CDW-1:0]   cfg_data;
  logic             cfg_valid;
  logic [CH-1:0]    s_valid;
  logic [CH*DW-1:0] s_data;
  logic [CH-1:0]    s_ready, busy, done;
  logic [IW-1:0]    axi_awid, axi_wid;
  logic [AW-1:0]    axi_awaddr;
  logic [LW-1:0]    axi_awlen;
  logic             axi_awvalid, axi_awready;
  logic [DW-1:0]    axi_wdata;
  logic [DW/8-1:0]  axi_wstrb;
  logic             axi_wlast, axi_wvalid, axi_wready, axi_bready;

  always #5 clk = ~clk;

  axis_write_mc #(
    .CHANNELS(CH), .CFG_AWIDTH(CAW), .CFG_DWIDTH(CDW), .AXI_ID_WIDTH(IW),
    .AXI_LEN_WIDTH(LW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy), .done(done),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wid(axi_wid),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bready(axi_bready)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model: per-channel address/remaining plus the current burst.
  logic [AW-1:0] m_addr [CH];
  int unsigned   m_rem  [CH];
  int unsigned   m_seq  [CH];
  logic [CH-1:0] m_busy, m_done;
  int            m_ph;        // 0 waiting for grant, 1 address offered, 2 data beats
  int            m_cur, m_left, m_ptr, m_len;
  logic [AW-1:0] m_awaddr;
  int            done_seen [CH];
  int            stall_cycles;
  int            log_id [$];
  int            log_len [$];
  logic [AW-1:0] log_addr [$];

  function automatic logic [63:0] pat(input int c, input int unsigned s);
    return {16'(c), 16'(s) ^ 16'h5A5A, 32'(s) * 32'h9E3779B1};
  endfunction

  function automatic int burst_len(input logic [AW-1:0] a, input int unsigned rem);
    int l;
    int pg;
    l  = MAXB;
    pg = (4096 - int'(a % 4096)) / (DW / 8);
    if (pg < l) l = pg;
    if (int'(rem) < l) l = int'(rem);
    return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_addr[c] = '0;
      m_rem[c]  = 0;
    end
    m_busy = '0;
    m_done = '0;
    m_ph   = 0;
    m_ptr  = 0;
    m_cur  = 0;
    m_left = 0;
  endtask

  task automatic drive_data();
    for (int c = 0; c < CH; c++) s_data[c*DW +: DW] = pat(c, m_seq[c]);
  endtask

  task automatic clear_log();
    log_id.delete();
    log_len.delete();
    log_addr.delete();
    stall_cycles = 0;
    for (int c = 0; c < CH; c++) done_seen[c] = 0;
  endtask

  task automatic sample();
    logic [CH-1:0] exp_rdy, busy_now, elig;
    int ch;
    bit found;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("bready", axi_bready, 1);
    chk("awvalid", axi_awvalid, m_ph == 1);
    if (m_ph == 1) begin
      chk("awid", axi_awid, m_cur);
      chk("awaddr", axi_awaddr, m_awaddr);
      chk("awlen", axi_awlen, m_len);
    end
    chk("wvalid", axi_wvalid, (m_ph == 2) && s_valid[m_cur]);
    exp_rdy = '0;
    if (m_ph == 2 && axi_wready) exp_rdy[m_cur] = 1'b1;
    chk("s_ready", s_ready, exp_rdy);
    if (m_ph == 2 && s_valid[m_cur]) begin
      chk("wid", axi_wid, m_cur);
      chk("wdata", axi_wdata, pat(m_cur, m_seq[m_cur]));
      chk("wlast", axi_wlast, m_left == 1);
    end
    for (int c = 0; c < CH; c++) if (done[c]) done_seen[c]++;
    if (m_ph == 2 && !axi_wvalid) stall_cycles++;

    busy_now = m_busy;
    m_done   = '0;
    if (cfg_valid && rst_n) begin
      ch = int'(cfg_addr >> 1);
      if (ch < CH && !busy_now[ch]) begin
        if (!cfg_addr[0]) m_addr[ch] = cfg_data & ~32'h7;
        else if (cfg_data != 0) begin
          m_rem[ch]  = cfg_data;
          m_busy[ch] = 1'b1;
        end
      end
    end
    if (rst_n) begin
      case (m_ph)
        0: begin
          elig  = busy_now & s_valid;
          found = 0;
          for (int i = 0; i < CH; i++) begin
            ch = (m_ptr + i) % CH;
            if (!found && elig[ch]) begin
              found    = 1;
              m_cur    = ch;
              m_left   = burst_len(m_addr[ch], m_rem[ch]);
              m_len    = m_left - 1;
              m_awaddr = m_addr[ch];
              m_ph     = 1;
            end
          end
        end
        1: if (axi_awready) begin
          m_ph = 2;
          log_id.push_back(m_cur);
          log_len.push_back(m_len);
          log_addr.push_back(m_awaddr);
        end
        default: if (s_valid[m_cur] && axi_wready) begin
          m_seq[m_cur]++;
          m_rem[m_cur]--;
          m_addr[m_cur] += AW'(DW / 8);
          m_left--;
          if (m_rem[m_cur] == 0) begin
            m_busy[m_cur] = 1'b0;
            m_done[m_cur] = 1'b1;
          end
          if (m_left == 0) begin
            m_ph  = 0;
            m_ptr = (m_cur + 1) % CH;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive_data();
  endtask

  task automatic cfg_wr(input int ch, input int r, input logic [31:0] d);
    cfg_addr  = CAW'((ch << 1) | r);
    cfg_data  = d;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic run_idle(input int maxc, input string name);
    int n = 0;
    while ((m_busy != 0 || m_ph != 0) && n < maxc) begin
      step();
      n++;
    end
    chk({name, "_drain"}, (m_busy == 0 && m_ph == 0), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_addr = '0; cfg_data = '0; cfg_valid = 1'b0;
    s_valid = '0; axi_awready = 1'b0; axi_wready = 1'b0;
    for (int c = 0; c < CH; c++) m_seq[c] = 0;
    model_reset();
    clear_log();
    drive_data();
    #2;
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bready", axi_bready, 1);
    chk("rst_wstrb", axi_wstrb, 8'hFF);
    chk("rst_sready", s_ready, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: single short burst
    axi_awready = 1'b1; axi_wready = 1'b1; s_valid = '1;
    clear_log();
    cfg_wr(0, 0, 32'h1000);
    cfg_wr(0, 1, 4);
    run_idle(100, "t1");
    chk("t1_nbursts", log_id.size(), 1);
    if (log_id.size() >= 1) begin
      chk("t1_id", log_id[0], 0);
      chk("t1_addr", log_addr[0], 32'h1000);
      chk("t1_len", log_len[0], 3);
    end
    step();
    chk("t1_done_once", done_seen[0], 1);

    // 2: 4 KiB split
    clear_log();
    cfg_wr(1, 0, 32'h0FF0);
    cfg_wr(1, 1, 8);
    run_idle(100, "t2");
    chk("t2_nbursts", log_id.size(), 2);
    if (log_id.size() >= 2) begin
      chk("t2_addr0", log_addr[0], 32'h0FF0);
      chk("t2_len0", log_len[0], 1);
      chk("t2_addr1", log_addr[1], 32'h1000);
      chk("t2_len1", log_len[1], 5);
      chk("t2_id1", log_id[1], 1);
    end

    // 3: round-robin over all channels
    do_reset();
    clear_log();
    s_valid = '0;
    for (int c = 0; c < CH; c++) begin
      cfg_wr(c, 0, 32'(c * 32'h2000));
      cfg_wr(c, 1, 32);
    end
    s_valid = '1;
    run_idle(400, "t3");
    chk("t3_nbursts", log_id.size(), 8);
    for (int i = 0; i < log_id.size() && i < 8; i++) begin
      chk("t3_id", log_id[i], i % 4);
      chk("t3_len", log_len[i], 15);
    end

    // 4: upstream stall mid-burst
    clear_log();
    s_valid = 4'b0100;
    cfg_wr(2, 0, 32'h100);
    cfg_wr(2, 1, 8);
    for (int n = 0; n < 50 && !(m_ph == 2 && m_left == 5); n++) step();
    s_valid = '0;
    for (int n = 0; n < 5; n++) step();
    s_valid = 4'b0100;
    run_idle(100, "t4");
    chk("t4_stalls", stall_cycles, 5);
    chk("t4_nbursts", log_id.size(), 1);

    // 5: ignored cfg writes
    clear_log();
    s_valid = '0;
    cfg_wr(0, 0, 32'h2000);
    cfg_wr(0, 1, 40);
    cfg_wr(0, 1, 5);
    cfg_wr(0, 0, 32'h9000);
    cfg_wr(1, 1, 0);
    cfg_wr(7, 1, 9);
    cfg_wr(7, 0, 32'h4444);
    step();
    chk("t5_busy", busy, 4'b0001);
    s_valid = 4'b0011;
    run_idle(200, "t5");
    chk("t5_nbursts", log_id.size(), 3);
    if (log_id.size() >= 3) begin
      chk("t5_addr0", log_addr[0], 32'h2000);
      chk("t5_beats", log_len[0] + log_len[1] + log_len[2] + 3, 40);
      chk("t5_id2", log_id[2], 0);
    end

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) s_valid[c] = ($urandom_range(0, 99) < 80);
      axi_awready = ($urandom_range(0, 99) < 60);
      axi_wready  = ($urandom_range(0, 99) < 70);
      cfg_valid   = ($urandom_range(0, 99) < 10);
      cfg_addr    = CAW'($urandom_range(0, 15));
      if (!cfg_addr[0]) cfg_data = $urandom_range(0, 32'h3FFF);
      else cfg_data = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      step();
    end
    cfg_valid = 1'b0; s_valid = '1; axi_awready = 1'b1; axi_wready = 1'b1;
    run_idle(3000, "rand");

    // 6: asynchronous reset during data phase
    cfg_wr(3, 0, 32'h3000);
    cfg_wr(3, 1, 20);
    for (int n = 0; n < 40 && !(m_ph == 2 && m_left < 14); n++) step();
    chk("t6_in_data", m_ph, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_wvalid", axi_wvalid, 0);
    chk("t6_awvalid", axi_awvalid, 0);
    chk("t6_sready", s_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_wlast", axi_wlast, 0);
    chk("t6_wdata", axi_wdata, 0);
    chk("t6_bready", axi_bready, 1);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) step();
    chk("t6_busy_after", busy, 0);
    chk("t6_awvalid_after", axi_awvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
